// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM arbiter slice.
//   ADDR_W / LEN_W   : memory address and segment-length widths
//   PAGE_BYTES_DEF   : default PSRAM page size in bytes
//   MAX_BURST        : burst length encoded by vid_len == 0
//   MEM_RW_*         : mem_rw encoding
//   arb_state_e      : arbiter FSM states
package psram_pkg;

  localparam int unsigned ADDR_W         = 24;
  localparam int unsigned LEN_W          = 11;
  localparam int unsigned PAGE_BYTES_DEF = 1024;
  localparam int unsigned MAX_BURST      = 1024;

  localparam logic MEM_RW_READ  = 1'b0;
  localparam logic MEM_RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    WAIT_INIT  = 3'd0,
    IDLE       = 3'd1,
    VID_ISSUE  = 3'd2,
    VID_XFER   = 3'd3,
    HOST_ISSUE = 3'd4,
    HOST_XFER  = 3'd5,
    GAP        = 3'd6
  } arb_state_e;

endpackage

// File: rtl/psram_seg_calc.sv
// Page-boundary segment calculator (combinational).
//   addr             : segment start byte address
//   remaining        : bytes left in the burst (1..MAX_BURST)
//   seg_len_c        : bytes that fit before the next page boundary
//   next_addr_c      : addr + seg_len_c, wrapping at 2^ADDR_W
//   next_remaining_c : remaining - seg_len_c
module psram_seg_calc
  import psram_pkg::*;
#(
  parameter int unsigned PAGE_BYTES = PAGE_BYTES_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  remaining,
  output logic [LEN_W-1:0]  seg_len_c,
  output logic [ADDR_W-1:0] next_addr_c,
  output logic [LEN_W-1:0]  next_remaining_c
);

  localparam int unsigned PAGE_BITS = $clog2(PAGE_BYTES);

  logic [LEN_W-1:0] page_room;

  // Bytes from addr up to (not including) the next page boundary.
  assign page_room        = LEN_W'(PAGE_BYTES) - LEN_W'(addr[PAGE_BITS-1:0]);
  assign seg_len_c        = (remaining < page_room) ? remaining : page_room;
  assign next_addr_c      = addr + ADDR_W'(seg_len_c);
  assign next_remaining_c = remaining - seg_len_c;

endmodule

// File: rtl/psram_arbiter.sv
// Two-requester arbiter in front of the psram controller.
//   sysclk, reset                     : clock, async active-high reset
//   vid_req/addr/len -> vid_gnt/rdata/rvalid/done : video burst reads
//   host_req/we/addr/wdata -> host_rdata/ack      : host single-byte access
//   mem_ready, mem_wreq, mem_rdata/rvalid/done    : controller status
//   mem_start/rw/addr/len/wdata                   : controller command
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int unsigned PAGE_BYTES   = PAGE_BYTES_DEF,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CE_GAP       = 2
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [9:0]        vid_len,
  output logic              vid_gnt,
  output logic [7:0]        vid_rdata,
  output logic              vid_rvalid,
  output logic              vid_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_ack,
  input  logic              mem_ready,
  output logic              mem_start,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LEN_W-1:0]  mem_len,
  output logic [7:0]        mem_wdata,
  input  logic              mem_wreq,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  input  logic              mem_done
);

  localparam int unsigned GAP_W    = $clog2(CE_GAP + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e          state, state_n;
  logic [ADDR_W-1:0]   cur_addr;
  logic [LEN_W-1:0]    remaining;
  logic [GAP_W-1:0]    gap_cnt;
  logic [STARVE_W-1:0] starve_cnt;

  logic              grant_vid, grant_host, next_seg, vid_last, host_fin, gap_end;
  logic [ADDR_W-1:0] seg_addr;
  logic [LEN_W-1:0]  seg_rem;
  logic [LEN_W-1:0]  seg_len_c;
  logic [ADDR_W-1:0] next_addr_c;
  logic [LEN_W-1:0]  next_remaining_c;

  // The controller paces write data itself; the arbiter only holds mem_wdata.
  logic unused_ok;
  assign unused_ok = &{1'b0, mem_wreq};

  psram_seg_calc #(.PAGE_BYTES(PAGE_BYTES)) u_seg_calc (
    .addr             (seg_addr),
    .remaining        (seg_rem),
    .seg_len_c        (seg_len_c),
    .next_addr_c      (next_addr_c),
    .next_remaining_c (next_remaining_c)
  );

  // Next-state, arbitration and segment-source selection.
  always_comb begin
    state_n    = state;
    grant_vid  = 1'b0;
    grant_host = 1'b0;
    next_seg   = 1'b0;
    vid_last   = 1'b0;
    host_fin   = 1'b0;
    gap_end    = 1'b0;
    seg_addr   = cur_addr;
    seg_rem    = remaining;
    case (state)
      WAIT_INIT: if (mem_ready) state_n = IDLE;
      IDLE: begin
        seg_addr = vid_addr;
        seg_rem  = (vid_len == 10'd0) ? LEN_W'(MAX_BURST) : LEN_W'(vid_len);
        if (!mem_ready) begin
          state_n = WAIT_INIT;
        end else if (vid_req && (!host_req || starve_cnt < STARVE_W'(STARVE_LIMIT))) begin
          grant_vid = 1'b1;
          state_n   = VID_ISSUE;
        end else if (host_req) begin
          grant_host = 1'b1;
          state_n    = HOST_ISSUE;
        end
      end
      VID_ISSUE: state_n = VID_XFER;
      VID_XFER: if (mem_done) begin
        state_n  = GAP;
        vid_last = (remaining == '0);
      end
      HOST_ISSUE: state_n = HOST_XFER;
      HOST_XFER: if (mem_done) begin
        state_n  = GAP;
        host_fin = 1'b1;
      end
      GAP: if (gap_cnt == GAP_W'(CE_GAP - 1)) begin
        gap_end = 1'b1;
        // vid_gnt still high here means a split burst has segments left.
        if (!mem_ready) begin
          state_n = WAIT_INIT;
        end else if (vid_gnt) begin
          next_seg = 1'b1;
          state_n  = VID_ISSUE;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = WAIT_INIT;
    endcase
  end

  // State register and registered outputs/datapath.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_INIT;
      cur_addr   <= '0;
      remaining  <= '0;
      gap_cnt    <= '0;
      starve_cnt <= '0;
      vid_gnt    <= 1'b0;
      vid_rdata  <= '0;
      vid_rvalid <= 1'b0;
      vid_done   <= 1'b0;
      host_rdata <= '0;
      host_ack   <= 1'b0;
      mem_start  <= 1'b0;
      mem_rw     <= MEM_RW_READ;
      mem_addr   <= '0;
      mem_len    <= '0;
      mem_wdata  <= '0;
    end else begin
      state     <= state_n;
      mem_start <= grant_vid | grant_host | next_seg;
      vid_done  <= vid_last;
      host_ack  <= host_fin;
      gap_cnt   <= (state == GAP && !gap_end) ? gap_cnt + GAP_W'(1) : '0;

      if (grant_vid || next_seg) begin
        mem_addr  <= seg_addr;
        mem_len   <= seg_len_c;
        mem_rw    <= MEM_RW_READ;
        cur_addr  <= next_addr_c;
        remaining <= next_remaining_c;
      end
      if (grant_host) begin
        mem_addr  <= host_addr;
        mem_len   <= LEN_W'(1);
        mem_rw    <= host_we ? MEM_RW_WRITE : MEM_RW_READ;
        mem_wdata <= host_wdata;
      end

      if (grant_vid)                                  vid_gnt <= 1'b1;
      else if (vid_last || (gap_end && !mem_ready))   vid_gnt <= 1'b0;

      if (grant_vid)       starve_cnt <= host_req ? starve_cnt + STARVE_W'(1) : '0;
      else if (grant_host) starve_cnt <= '0;

      vid_rvalid <= (state == VID_XFER) && mem_rvalid;
      if (state == VID_XFER && mem_rvalid)  vid_rdata  <= mem_rdata;
      if (state == HOST_XFER && mem_rvalid) host_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter with a behavioural PSRAM controller.
module tb_psram_arbiter;

  localparam int CE_GAP = 2;

  logic        sysclk, reset;
  logic        vid_req;
  logic [23:0] vid_addr;
  logic [9:0]  vid_len;
  logic        vid_gnt, vid_rvalid, vid_done;
  logic [7:0]  vid_rdata;
  logic        host_req, host_we, host_ack;
  logic [23:0] host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic        mem_ready, mem_start, mem_rw, mem_wreq, mem_rvalid, mem_done;
  logic [23:0] mem_addr;
  logic [10:0] mem_len;
  logic [7:0]  mem_wdata, mem_rdata;

  psram_arbiter dut (
    .sysclk(sysclk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_len(vid_len),
    .vid_gnt(vid_gnt), .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid), .vid_done(vid_done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .mem_ready(mem_ready), .mem_start(mem_start), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_len(mem_len), .mem_wdata(mem_wdata), .mem_wreq(mem_wreq), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_done(mem_done)
  );

  initial sysclk = 1'b0;
  initial forever #5 sysclk = ~sysclk;

  int total = 0;
  int bad   = 0;

  // Memory contents: written bytes override a fixed address-derived pattern.
  logic [7:0] wmem    [logic [23:0]];
  logic [7:0] ref_mem [logic [23:0]];

  function automatic logic [7:0] bg(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] memval(input logic [23:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return bg(a);
  endfunction

  // Controller model: 2-cycle latency, one byte per cycle, then mem_done.
  initial begin
    logic [23:0] a;
    int          n;
    logic        rw;
    mem_rvalid = 1'b0; mem_done = 1'b0; mem_wreq = 1'b0; mem_rdata = 8'h00;
    forever begin
      @(negedge sysclk);
      if (!reset && mem_start) begin
        a = mem_addr; n = int'(mem_len); rw = mem_rw;
        @(negedge sysclk);
        @(negedge sysclk);
        if (!reset) begin
          if (rw) begin
            mem_wreq = 1'b1;
            wmem[a] = mem_wdata;
            @(negedge sysclk);
            mem_wreq = 1'b0;
          end else begin
            for (int i = 0; i < n && !reset; i++) begin
              logic [23:0] aa;
              aa = a + 24'(i);
              mem_rdata  = wmem.exists(aa) ? wmem[aa] : bg(aa);
              mem_rvalid = 1'b1;
              @(negedge sysclk);
            end
            mem_rvalid = 1'b0;
          end
          if (!reset) begin
            mem_done = 1'b1;
            @(negedge sysclk);
            mem_done = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: records commands, video bytes and protocol violations.
  logic [23:0] st_addr_q[$];
  logic [10:0] st_len_q[$];
  int          grants_q[$];
  logic [7:0]  vbytes_q[$];
  int cyc = 0, last_done_cyc = 0, start_cnt = 0, vdone_cnt = 0, proto_viol = 0;
  logic have_done = 1'b0, busy = 1'b0, prev_start = 1'b0;
  logic [35:0] cap_cmd;

  initial forever begin
    @(negedge sysclk);
    cyc++;
    if (reset) begin
      busy = 1'b0; prev_start = 1'b0; have_done = 1'b0;
    end else begin
      if (mem_start) begin
        start_cnt++;
        st_addr_q.push_back(mem_addr);
        st_len_q.push_back(mem_len);
        grants_q.push_back(vid_gnt ? 0 : 1);
        if (prev_start) proto_viol++;
        if (have_done && (cyc - last_done_cyc) < CE_GAP + 1) proto_viol++;
        busy = 1'b1;
        cap_cmd = {mem_addr, mem_len, mem_rw};
      end
      if (busy && {mem_addr, mem_len, mem_rw} !== cap_cmd) proto_viol++;
      if ((vid_done || host_ack) && !(have_done && cyc == last_done_cyc + 1)) proto_viol++;
      if (vid_rvalid) vbytes_q.push_back(vid_rdata);
      if (vid_done) vdone_cnt++;
      if (mem_done) begin busy = 1'b0; have_done = 1'b1; last_done_cyc = cyc; end
      prev_start = mem_start;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge sysclk);
    #1;
  endtask

  task automatic clr();
    st_addr_q.delete(); st_len_q.delete(); grants_q.delete(); vbytes_q.delete();
    start_cnt = 0; vdone_cnt = 0; proto_viol = 0;
  endtask

  // Reference segmentation: walk the burst, cutting at every 1024-byte page edge.
  logic [23:0] exp_addr_q[$];
  int          exp_len_q[$];
  logic [7:0]  exp_bytes_q[$];

  task automatic model_segs(input logic [23:0] addr, input logic [9:0] len);
    int unsigned a, rem, room, s;
    a   = 32'(addr);
    rem = (len == 10'd0) ? 1024 : 32'(len);
    exp_addr_q.delete(); exp_len_q.delete(); exp_bytes_q.delete();
    for (int unsigned i = 0; i < rem; i++) exp_bytes_q.push_back(memval(24'(a + i)));
    while (rem > 0) begin
      room = 1024 - (a % 1024);
      s    = (rem < room) ? rem : room;
      exp_addr_q.push_back(24'(a));
      exp_len_q.push_back(int'(s));
      a   = (a + s) % (1 << 24);
      rem = rem - s;
    end
  endtask

  task automatic run_burst(input logic [23:0] addr, input logic [9:0] len, input string tag);
    logic seen;
    int   nerr;
    model_segs(addr, len);
    clr();
    vid_addr = addr; vid_len = len; vid_req = 1'b1;
    step();
    chk({tag, "_grant"}, 64'({vid_gnt, mem_start}), 64'(2'b11));
    vid_addr = ~addr; vid_len = ~len;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      step();
      if (vid_done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'(1));
    chk({tag, "_gnt_drop"}, 64'(vid_gnt), 64'(0));
    vid_req = 1'b0;
    repeat (6) step();
    chk({tag, "_nseg"}, 64'(st_addr_q.size()), 64'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < st_addr_q.size(); i++) begin
      chk($sformatf("%s_seg%0d_addr", tag, i), 64'(st_addr_q[i]), 64'(exp_addr_q[i]));
      chk($sformatf("%s_seg%0d_len", tag, i), 64'(st_len_q[i]), 64'(exp_len_q[i]));
    end
    chk({tag, "_nbytes"}, 64'(vbytes_q.size()), 64'(exp_bytes_q.size()));
    nerr = 0;
    for (int i = 0; i < exp_bytes_q.size() && i < vbytes_q.size(); i++)
      if (vbytes_q[i] !== exp_bytes_q[i]) nerr++;
    chk({tag, "_byte_errs"}, 64'(nerr), 64'(0));
    chk({tag, "_vdone_cnt"}, 64'(vdone_cnt), 64'(1));
    chk({tag, "_proto"}, 64'(proto_viol), 64'(0));
  endtask

  task automatic host_op(input logic we, input logic [23:0] addr, input logic [7:0] wd,
                         input string tag, output logic [7:0] rd);
    logic seen;
    clr();
    host_we = we; host_addr = addr; host_wdata = wd; host_req = 1'b1;
    step();
    chk({tag, "_start"}, 64'({mem_start, mem_rw, mem_addr, mem_len}),
        64'({1'b1, we, addr, 11'd1}));
    host_we = ~we; host_addr = ~addr; host_wdata = ~wd;
    seen = 1'b0; rd = 8'h00;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (host_ack) begin seen = 1'b1; rd = host_rdata; end
    end
    host_req = 1'b0;
    chk({tag, "_ack"}, 64'(seen), 64'(1));
    repeat (4) step();
    chk({tag, "_proto"}, 64'(proto_viol), 64'(0));
    if (we) ref_mem[addr] = wd;
  endtask

  initial begin
    logic [7:0]  rd;
    logic [23:0] ra;
    logic [7:0]  rdat;
    int          cnt, exp_g, s0;
    logic        seen;

    reset = 1'b1; mem_ready = 1'b0;
    vid_req = 1'b0; vid_addr = '0; vid_len = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) step();
    chk("reset_outs_a", 64'({vid_gnt, vid_rdata, vid_rvalid, vid_done, host_rdata, host_ack}), 64'(0));
    chk("reset_outs_b", 64'({mem_start, mem_rw, mem_addr, mem_len, mem_wdata}), 64'(0));

    // No command before the controller reports ready.
    reset = 1'b0;
    vid_addr = 24'h000100; vid_len = 10'd16; vid_req = 1'b1;
    repeat (6) step();
    chk("no_start_before_ready", 64'(start_cnt), 64'(0));
    vid_req = 1'b0;
    mem_ready = 1'b1;
    repeat (4) step();

    run_burst(24'h000100, 10'd16,  "single");
    repeat (3) step();
    run_burst(24'h0003F8, 10'd32,  "page_split");
    repeat (3) step();
    run_burst(24'hFFFFFC, 10'd8,   "top_wrap");
    repeat (3) step();
    run_burst(24'h000C00, 10'd0,   "len1024");
    repeat (3) step();

    host_op(1'b1, 24'h123456, 8'hA5, "host_wr", rd);
    repeat (3) step();
    host_op(1'b0, 24'h123456, 8'h00, "host_rd", rd);
    chk("host_rd_data", 64'(rd), 64'(8'hA5));
    repeat (3) step();

    // Random host traffic in a small window so reads hit earlier writes.
    for (int k = 0; k < 8; k++) begin
      ra = 24'h300000 + 24'($urandom_range(0, 7));
      if (k % 2 == 0) begin
        rdat = 8'($urandom());
        host_op(1'b1, ra, rdat, $sformatf("rnd_wr%0d", k), rd);
      end else begin
        host_op(1'b0, ra, 8'h00, $sformatf("rnd_rd%0d", k), rd);
        chk($sformatf("rnd_rd%0d_data", k), 64'(rd), 64'(memval(ra)));
      end
      repeat (2) step();
    end

    // Random bursts, including a window that overlaps host-written bytes.
    for (int k = 0; k < 6; k++) begin
      if (k == 0) ra = 24'h2FFFF0;
      else        ra = 24'($urandom());
      run_burst(ra, 10'($urandom_range(0, 1023)), $sformatf("rnd_burst%0d", k));
      repeat (2) step();
    end

    // Both requesters held: video gets STARVE_LIMIT grants, then host is forced.
    clr();
    vid_addr = 24'h000200; vid_len = 10'd4;
    host_we = 1'b0; host_addr = 24'h000010;
    vid_req = 1'b1; host_req = 1'b1;
    for (int i = 0; i < 4000 && grants_q.size() < 10; i++) step();
    vid_req = 1'b0; host_req = 1'b0;
    repeat (40) step();
    chk("starve_ngrants_min", 64'(grants_q.size() >= 10), 64'(1));
    cnt = 0;
    for (int k = 0; k < 10 && k < grants_q.size(); k++) begin
      if (cnt < 4) begin exp_g = 0; cnt++; end
      else         begin exp_g = 1; cnt = 0; end
      chk($sformatf("starve_grant%0d", k), 64'(grants_q[k]), 64'(exp_g));
    end
    chk("starve_proto", 64'(proto_viol), 64'(0));

    // Reset in the middle of a video transfer.
    clr();
    vid_addr = 24'h000800; vid_len = 10'd64; vid_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (vbytes_q.size() >= 4) seen = 1'b1;
    end
    chk("rst_mid_reached", 64'(seen), 64'(1));
    s0 = start_cnt;
    reset = 1'b1; mem_ready = 1'b0;
    step();
    chk("rst_mid_outs_a", 64'({vid_gnt, vid_rdata, vid_rvalid, vid_done, host_rdata, host_ack}), 64'(0));
    chk("rst_mid_outs_b", 64'({mem_start, mem_rw, mem_addr, mem_len, mem_wdata}), 64'(0));
    step();
    reset = 1'b0;
    repeat (8) step();
    chk("rst_no_start", 64'(start_cnt), 64'(s0));
    chk("rst_no_gnt", 64'(vid_gnt), 64'(0));
    vid_req = 1'b0;
    mem_ready = 1'b1;
    repeat (4) step();
    run_burst(24'h000800, 10'd64, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psram_arbiter.md
# psram_arbiter

- Shares the single `psram` controller between two requesters: the video scanout (burst reads, latency-critical) and the host bus (single-byte reads/writes).
- Sits between the RAMDAC front end and `psram`. Arbitrates between the two requesters and guarantees the host is not starved.
- Splits video bursts at PSRAM page boundaries.
- Enforces the minimum CE-high gap between transactions.

## Interface
- `PAGE_BYTES`, 1024, PSRAM page size; no memory transaction crosses a multiple of it.
- `STARVE_LIMIT`, 4, consecutive video grants allowed while host pending before host is forced.
- `CE_GAP`, 2, idle cycles between consecutive memory transactions.
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `sysclk  in  1  system clock; all logic on posedge`
  - `reset  in  1  asynchronous active-high reset`
- Video port:
  - `vid_req  in  1  level; burst read request, held until vid_done`
  - `vid_addr  in  24  burst start byte address`
  - `vid_len  in  10  burst length in bytes; 0 means 1024`
  - `vid_gnt  out  1  high from grant until vid_done`
  - `vid_rdata  out  8  read byte`
  - `vid_rvalid  out  1  vid_rdata valid, one cycle per byte`
  - `vid_done  out  1  one-cycle pulse after last byte`
- Host port:
  - `host_req  in  1  level; held until host_ack`
  - `host_we  in  1  1 = write, 0 = read`
  - `host_addr  in  24  byte address`
  - `host_wdata  in  8  write byte`
  - `host_rdata  out  8  read byte, valid with host_ack`
  - `host_ack  out  1  one-cycle completion pulse`
- Memory-controller side:
  - `mem_ready  in  1  controller initialisation complete`
  - `mem_start  out  1  one-cycle command pulse`
  - `mem_rw  out  1  1 = write, 0 = read`
  - `mem_addr  out  24  segment start address`
  - `mem_len  out  11  segment length, 1..1024`
  - `mem_wdata  out  8  write byte`
  - `mem_wreq  in  1  controller consumes mem_wdata this cycle`
  - `mem_rdata  in  8  read byte`
  - `mem_rvalid  in  1  read byte valid`
  - `mem_done  in  1  one-cycle pulse, segment complete`

## Operation
- **States:**
  - `WAIT_INIT`: go to `IDLE` when `mem_ready`=1.
  - `IDLE`: arbitrate; go to `VID_ISSUE` or `HOST_ISSUE`.
  - `VID_ISSUE`: pulse `mem_start` with the current segment; go to `VID_XFER`.
  - `VID_XFER`: pass read data through. On `mem_done`, go to `GAP` and then `VID_ISSUE` if bytes remain, otherwise pulse `vid_done` and go to `GAP`.
  - `HOST_ISSUE`: pulse `mem_start` with length 1; go to `HOST_XFER`.
  - `HOST_XFER`: complete the host access; on `mem_done`, pulse `host_ack` and go to `GAP`.
  - `GAP`: count `CE_GAP` cycles, then go to `IDLE` (or back to `VID_ISSUE` while a video burst is mid-split).
- **Arbitration in `IDLE`:**
  - Video wins if both requests are present and `starve_cnt < STARVE_LIMIT`; otherwise the host wins.
  - `starve_cnt` increments on each video grant made while `host_req`=1.
  - It clears on any host grant, and also on any video grant made while `host_req`=0.
- **Segment arithmetic:**
  - `seg_len = min(remaining, PAGE_BYTES - (addr mod PAGE_BYTES))`.
  - After each segment: `addr += seg_len` modulo 2^24, and `remaining -= seg_len`.
- **Bursts are atomic:** a split video burst is never interleaved with host accesses.
- **Host write data:** `mem_wdata` = captured `host_wdata`. `mem_wreq` has no effect outside `HOST_XFER`.
- **Host read data:** `host_rdata` captures `mem_rdata` on `mem_rvalid` in `HOST_XFER`.
- **Video read data:** `vid_rdata`/`vid_rvalid` are `mem_rdata`/`mem_rvalid` registered by one cycle, in `VID_XFER` only.
- **Request capture:** addresses, length, `host_we` and `host_wdata` are captured at grant. Later changes are ignored until done/ack.
- **Reset mid-transaction:** reset immediately returns the block to `WAIT_INIT` with all outputs at their reset values. Requesters must re-request.
- **`mem_ready` falling:** if `mem_ready` drops outside `WAIT_INIT`, the block finishes the current segment and then returns to `WAIT_INIT`.

## Timing
- **Reset values:** every output is 0; state `WAIT_INIT`; `starve_cnt`=0.
- **Grant latency:** request high in `IDLE` at cycle N → `vid_gnt` or internal grant at N+1, `mem_start` at N+1.
- **`mem_start`:** asserted for exactly one cycle per segment.
- **Control outputs:** `mem_addr`, `mem_len` and `mem_rw` are stable from `mem_start` until `mem_done`.
- **Completion:** `vid_done` and `host_ack` occur one cycle after the final `mem_done`.
- **Back-to-back transactions:** a new `mem_start` occurs at least `CE_GAP`+1 cycles after the preceding `mem_done`.
- **`vid_gnt`:** drops in the same cycle as `vid_done`.

## Structure
- **Package `psram_pkg`:**
  - arbiter state enum;
  - `PAGE_BYTES` default;
  - the `mem_rw` encoding;
  - address width 24.
- **Sub-module `psram_seg_calc`:** combinational.
  - Inputs: addr, remaining.
  - Outputs: `seg_len`, next addr, next remaining.
  - Instantiated once.

## Test plan
- **Single burst, no split:** `vid_req` with addr 0x000100, len 16 → one `mem_start` with len 16; 16 `vid_rvalid`; `vid_done` once.
- **Page split:** addr 0x0003F8, len 32 → segments (0x0003F8, 8) and (0x000400, 24), separated by ≥3 cycles; one `vid_done`.
- **Top-of-memory wrap:** addr 0xFFFFFC, len 8 → segments (0xFFFFFC, 4) and (0x000000, 4).
- **Starvation guard:** `vid_req` and `host_req` held continuously → grants V,V,V,V,H,V,V,V,V,H.
- **Host accesses:**
  - host write 0xA5 to 0x123456, then host read of 0x123456 (memory model echoes) → `host_rdata`=0xA5 with `host_ack`.
  - `vid_len`=0 → one `mem_start` with len 1024 at a page-aligned address.
- **Reset mid-burst:** assert `reset` during `VID_XFER` → all outputs 0 the next cycle; no `mem_start` until `mem_ready`.
